// File: rtl/openofdm_rx_pkt_monitor_if.sv
// Bus between the dot11 rx core (plus the record reader) and the packet monitor.
// master drives header/byte/FCS events and pops; slave is the monitor itself.
interface openofdm_rx_pkt_monitor_if #(
  parameter int RSSI_HALF_DB_WIDTH = 11,
  parameter int FIFO_DEPTH_LOG2    = 4
);
  logic                                 enable;
  logic signed [RSSI_HALF_DB_WIDTH-1:0] rssi_half_db;
  logic                                 pkt_header_valid_strobe;
  logic                                 pkt_header_valid;
  logic                                 ht_unsupport;
  logic [7:0]                           pkt_rate;
  logic [15:0]                          pkt_len;
  logic                                 ht_sgi;
  logic                                 byte_out_strobe;
  logic                                 fcs_out_strobe;
  logic                                 fcs_ok;
  logic [15:0]                          timeout_cycles;
  logic                                 rd_en;
  logic [63:0]                          rd_data;
  logic                                 rd_valid;
  logic [FIFO_DEPTH_LOG2:0]             fifo_level;
  logic                                 fifo_empty;
  logic                                 fifo_full;
  logic [15:0]                          drop_count;

  modport master (
    output enable, rssi_half_db, pkt_header_valid_strobe, pkt_header_valid,
           ht_unsupport, pkt_rate, pkt_len, ht_sgi, byte_out_strobe,
           fcs_out_strobe, fcs_ok, timeout_cycles, rd_en,
    input  rd_data, rd_valid, fifo_level, fifo_empty, fifo_full, drop_count
  );

  modport slave (
    input  enable, rssi_half_db, pkt_header_valid_strobe, pkt_header_valid,
           ht_unsupport, pkt_rate, pkt_len, ht_sgi, byte_out_strobe,
           fcs_out_strobe, fcs_ok, timeout_cycles, rd_en,
    output rd_data, rd_valid, fifo_level, fifo_empty, fifo_full, drop_count
  );
endinterface

// File: rtl/openofdm_rx_pkt_monitor.sv
// Per-packet 64-bit status records queued in a FIFO, with sequence numbers and a drop counter.
// Define OPENOFDM_RX_RSSI_PEAK_EN to record peak RSSI over the packet instead of the header-cycle value.
module openofdm_rx_pkt_monitor #(
  parameter int RSSI_HALF_DB_WIDTH = 11,
  parameter int FIFO_DEPTH_LOG2    = 4
) (
  input logic                      clock,
  input logic                      reset,
  openofdm_rx_pkt_monitor_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam logic [FIFO_DEPTH_LOG2:0] LEVEL_FULL = (FIFO_DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, DATA} state_t;

  typedef struct packed {
    logic [7:0]  seq;
    logic [15:0] bytes;
    logic        aborted;
    logic        fcs_ok;
    logic        header_invalid;
    logic        ht_unsupport;
    logic        sgi;
    logic [10:0] rssi;
    logic [15:0] len;
    logic [7:0]  rate;
  } record_t;

  state_t                     state_q, state_d;
  logic [7:0]                 rate_q;
  logic [15:0]                len_q;
  logic                       sgi_q;
  logic signed [10:0]         rssi_q;
  logic [15:0]                byte_cnt_q;
  logic [15:0]                idle_cnt_q;
  logic [7:0]                 seq_q;
  logic                       stage_valid_q;
  record_t                    stage_rec_q;
  logic                       defer_valid_q;
  record_t                    defer_rec_q;
  record_t                    mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_DEPTH_LOG2:0]   level_q;
  logic [63:0]                rd_data_q;
  logic                       rd_valid_q;
  logic [15:0]                drop_q;

  logic signed [10:0] rssi_now, rssi_rec;
  logic [15:0]        bytes_now;
  logic               hdr_good, timeout_hit;
  logic               full, empty, wr_fire, rd_fire;
  record_t            live_rec, reject_rec;
  logic               emit, defer, load_hdr, hdr_drop;
  record_t            emit_rec, defer_rec;
  logic [1:0]         drop_inc;
  logic [16:0]        drop_sum;

  assign rssi_now = 11'($signed(bus.rssi_half_db[RSSI_HALF_DB_WIDTH-1:0]));

`ifdef OPENOFDM_RX_RSSI_PEAK_EN
  assign rssi_rec = (rssi_now > rssi_q) ? rssi_now : rssi_q;
`else
  assign rssi_rec = rssi_q;
`endif

  assign bytes_now = (bus.byte_out_strobe && byte_cnt_q != 16'hFFFF) ? byte_cnt_q + 16'd1 : byte_cnt_q;
  assign hdr_good  = bus.pkt_header_valid && !bus.ht_unsupport;
  // Fires when timeout_cycles cycles have elapsed since the last byte (or DATA entry).
  assign timeout_hit = (state_q == DATA) && (bus.timeout_cycles != 16'd0) && !bus.byte_out_strobe &&
                       (({1'b0, idle_cnt_q} + 17'd1) == {1'b0, bus.timeout_cycles});

  assign full    = (level_q == LEVEL_FULL);
  assign empty   = (level_q == '0);
  assign wr_fire = stage_valid_q && !full;
  assign rd_fire = bus.rd_en && !empty;

  always_comb begin
    live_rec       = '0;
    live_rec.bytes = bytes_now;
    live_rec.sgi   = sgi_q;
    live_rec.rssi  = rssi_rec;
    live_rec.len   = len_q;
    live_rec.rate  = rate_q;

    reject_rec                = '0;
    reject_rec.header_invalid = !bus.pkt_header_valid;
    reject_rec.ht_unsupport   = bus.ht_unsupport;
    reject_rec.sgi            = bus.ht_sgi;
    reject_rec.rssi           = rssi_now;
    reject_rec.len            = bus.pkt_len;
    reject_rec.rate           = bus.pkt_rate;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_rec  = '0;
    defer     = 1'b0;
    defer_rec = '0;
    load_hdr  = 1'b0;
    hdr_drop  = 1'b0;
    if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.pkt_header_valid_strobe) begin
            if (hdr_good) begin
              load_hdr = 1'b1;
              state_d  = DATA;
            end else begin
              emit     = 1'b1;
              emit_rec = reject_rec;
            end
          end
        end
        DATA: begin
          if (bus.fcs_out_strobe) begin
            emit            = 1'b1;
            emit_rec        = live_rec;
            emit_rec.fcs_ok = bus.fcs_ok;
            hdr_drop        = bus.pkt_header_valid_strobe;
            state_d         = IDLE;
          end else if (bus.pkt_header_valid_strobe) begin
            emit             = 1'b1;
            emit_rec         = live_rec;
            emit_rec.aborted = 1'b1;
            if (hdr_good) begin
              load_hdr = 1'b1;
            end else begin
              // Only one record per cycle can enter the FIFO, so the reject waits a cycle.
              defer     = 1'b1;
              defer_rec = reject_rec;
              state_d   = IDLE;
            end
          end else if (timeout_hit) begin
            emit             = 1'b1;
            emit_rec         = live_rec;
            emit_rec.aborted = 1'b1;
            state_d          = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    emit_rec.seq  = seq_q;
    defer_rec.seq = seq_q + 8'd1;
  end

  assign drop_inc = {1'b0, stage_valid_q && full} + {1'b0, hdr_drop} + {1'b0, defer_valid_q && emit};
  assign drop_sum = {1'b0, drop_q} + 17'(drop_inc);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      rate_q        <= '0;
      len_q         <= '0;
      sgi_q         <= 1'b0;
      rssi_q        <= '0;
      byte_cnt_q    <= '0;
      idle_cnt_q    <= '0;
      seq_q         <= '0;
      stage_valid_q <= 1'b0;
      stage_rec_q   <= '0;
      defer_valid_q <= 1'b0;
      defer_rec_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      rd_data_q     <= '0;
      rd_valid_q    <= 1'b0;
      drop_q        <= '0;
    end else begin
      state_q <= state_d;

      if (load_hdr) begin
        rate_q     <= bus.pkt_rate;
        len_q      <= bus.pkt_len;
        sgi_q      <= bus.ht_sgi;
        rssi_q     <= rssi_now;
        byte_cnt_q <= '0;
        idle_cnt_q <= '0;
      end else if (state_q == DATA) begin
        byte_cnt_q <= bytes_now;
        if (bus.byte_out_strobe)
          idle_cnt_q <= '0;
        else if (idle_cnt_q != 16'hFFFF)
          idle_cnt_q <= idle_cnt_q + 16'd1;
`ifdef OPENOFDM_RX_RSSI_PEAK_EN
        rssi_q <= rssi_rec;
`endif
      end

      seq_q <= seq_q + 8'(emit) + 8'(defer);

      if (defer_valid_q) begin
        stage_valid_q <= 1'b1;
        stage_rec_q   <= defer_rec_q;
      end else begin
        stage_valid_q <= emit;
        stage_rec_q   <= emit_rec;
      end
      defer_valid_q <= defer;
      defer_rec_q   <= defer_rec;

      if (wr_fire) wr_ptr_q <= wr_ptr_q + FIFO_DEPTH_LOG2'(1);
      if (rd_fire) begin
        rd_ptr_q  <= rd_ptr_q + FIFO_DEPTH_LOG2'(1);
        rd_data_q <= mem[rd_ptr_q];
      end
      rd_valid_q <= rd_fire;
      level_q    <= level_q + (FIFO_DEPTH_LOG2+1)'(wr_fire) - (FIFO_DEPTH_LOG2+1)'(rd_fire);
      drop_q     <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

  // NOTE: the record storage has no reset; the pointers and level define what is valid.
  always_ff @(posedge clock) begin
    if (wr_fire) mem[wr_ptr_q] <= stage_rec_q;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.fifo_level = level_q;
  assign bus.fifo_empty = empty;
  assign bus.fifo_full  = full;
  assign bus.drop_count = drop_q;
endmodule

// File: tb/tb_openofdm_rx_pkt_monitor.sv
// Directed bench for openofdm_rx_pkt_monitor: header/byte/FCS sequences, timeout, FIFO overflow,
// collisions and enable gating, with hand-derived record values.
module tb_openofdm_rx_pkt_monitor;
  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  openofdm_rx_pkt_monitor_if #(.RSSI_HALF_DB_WIDTH(11), .FIFO_DEPTH_LOG2(4)) bus ();

  openofdm_rx_pkt_monitor #(.RSSI_HALF_DB_WIDTH(11), .FIFO_DEPTH_LOG2(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rec(input int seq, input int nbytes, input logic ab, input logic fo,
                                      input logic inv, input logic ht, input logic sgi,
                                      input int rssi, input int len, input int rate);
    logic [10:0] r;
    r = rssi[10:0];
    return {seq[7:0], nbytes[15:0], ab, fo, inv, ht, sgi, r, len[15:0], rate[7:0]};
  endfunction

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic header(input logic v, input logic ht, input logic sgi, input logic [7:0] rate,
                        input logic [15:0] len, input logic signed [10:0] rssi);
    bus.pkt_header_valid_strobe = 1'b1;
    bus.pkt_header_valid        = v;
    bus.ht_unsupport            = ht;
    bus.ht_sgi                  = sgi;
    bus.pkt_rate                = rate;
    bus.pkt_len                 = len;
    bus.rssi_half_db            = rssi;
    tick();
    bus.pkt_header_valid_strobe = 1'b0;
  endtask

  task automatic send_bytes(input int n);
    bus.byte_out_strobe = 1'b1;
    tick(n);
    bus.byte_out_strobe = 1'b0;
  endtask

  task automatic fcs(input logic ok);
    bus.fcs_out_strobe = 1'b1;
    bus.fcs_ok         = ok;
    tick();
    bus.fcs_out_strobe = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [63:0] exp);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check({tag, "_valid"}, 64'(bus.rd_valid), 64'd1);
    check(tag, bus.rd_data, exp);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k_fire;
    reset                       = 1'b1;
    bus.enable                  = 1'b0;
    bus.rssi_half_db            = '0;
    bus.pkt_header_valid_strobe = 1'b0;
    bus.pkt_header_valid        = 1'b0;
    bus.ht_unsupport            = 1'b0;
    bus.pkt_rate                = '0;
    bus.pkt_len                 = '0;
    bus.ht_sgi                  = 1'b0;
    bus.byte_out_strobe         = 1'b0;
    bus.fcs_out_strobe          = 1'b0;
    bus.fcs_ok                  = 1'b0;
    bus.timeout_cycles          = '0;
    bus.rd_en                   = 1'b0;
    tick(3);
    reset = 1'b0;

    check("rst_rd_data", bus.rd_data, 64'd0);
    check("rst_rd_valid", 64'(bus.rd_valid), 64'd0);
    check("rst_level", 64'(bus.fifo_level), 64'd0);
    check("rst_empty", 64'(bus.fifo_empty), 64'd1);
    check("rst_full", 64'(bus.fifo_full), 64'd0);
    check("rst_drop", 64'(bus.drop_count), 64'd0);

    // Good packet: 100 bytes, FCS ok
    bus.enable = 1'b1;
    header(1'b1, 1'b0, 1'b0, 8'h0B, 16'd100, -11'sd40);
    check("t1_no_rec_on_hdr", 64'(bus.fifo_level), 64'd0);
    send_bytes(100);
    fcs(1'b1);
    check("t1_level_fcs_edge", 64'(bus.fifo_level), 64'd0);
    tick();
    check("t1_level_next_edge", 64'(bus.fifo_level), 64'd1);
    pop("t1_rec", 64'h00006447D800640B);
    tick();
    check("t1_valid_pulse", 64'(bus.rd_valid), 64'd0);
    check("t1_data_holds", bus.rd_data, 64'h00006447D800640B);
    check("t1_empty", 64'(bus.fifo_empty), 64'd1);

    // Invalid header: immediate reject, stays IDLE (later FCS ignored)
    header(1'b0, 1'b0, 1'b0, 8'h0D, 16'd20, -11'sd10);
    check("t2_level_hdr_edge", 64'(bus.fifo_level), 64'd0);
    tick();
    check("t2_level", 64'(bus.fifo_level), 64'd1);
    fcs(1'b1);
    tick(2);
    check("t2_idle_ignores_fcs", 64'(bus.fifo_level), 64'd1);
    pop("t2_rec", rec(1, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -10, 20, 8'h0D));

    // Timeout of 50 cycles after the 10th byte
    bus.timeout_cycles = 16'd50;
    header(1'b1, 1'b0, 1'b0, 8'h1B, 16'd200, -11'sd20);
    send_bytes(10);
    k_fire = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      if (bus.fifo_level != 0) begin
        k_fire = k;
        break;
      end
    end
    check("t3_timeout_latency", 64'(k_fire), 64'd51);
    pop("t3_rec", rec(2, 10, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -20, 200, 8'h1B));

    // Timeout disabled: no record during long silence
    bus.timeout_cycles = 16'd0;
    header(1'b1, 1'b0, 1'b0, 8'h24, 16'd300, -11'sd33);
    send_bytes(3);
    tick(200);
    check("t3_no_timeout", 64'(bus.fifo_level), 64'd0);
    fcs(1'b0);
    tick();
    pop("t3_fcs_bad_rec", rec(3, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -33, 300, 8'h24));

    // Overflow: 20 back-to-back rejects into a 16-entry FIFO
    do_reset();
    check("t4_rst_drop", 64'(bus.drop_count), 64'd0);
    bus.pkt_header_valid_strobe = 1'b1;
    bus.pkt_header_valid        = 1'b0;
    bus.ht_unsupport            = 1'b0;
    bus.ht_sgi                  = 1'b0;
    bus.pkt_rate                = 8'h30;
    bus.pkt_len                 = 16'd8;
    bus.rssi_half_db            = -11'sd1;
    tick(20);
    bus.pkt_header_valid_strobe = 1'b0;
    tick(2);
    check("t4_full", 64'(bus.fifo_full), 64'd1);
    check("t4_level", 64'(bus.fifo_level), 64'd16);
    check("t4_drop", 64'(bus.drop_count), 64'd4);
    for (int i = 0; i < 16; i++)
      pop($sformatf("t4_drain%0d", i), rec(i, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8, 8'h30));
    check("t4_empty_after", 64'(bus.fifo_empty), 64'd1);
    bus.rd_en = 1'b1;
    tick();
    bus.rd_en = 1'b0;
    check("t4_pop_empty_valid", 64'(bus.rd_valid), 64'd0);
    check("t4_pop_empty_data", bus.rd_data, rec(15, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -1, 8, 8'h30));

    // FCS and header in the same DATA cycle: FCS wins, header dropped
    do_reset();
    header(1'b1, 1'b0, 1'b0, 8'h0B, 16'd50, -11'sd30);
    send_bytes(5);
    bus.fcs_out_strobe          = 1'b1;
    bus.fcs_ok                  = 1'b1;
    bus.pkt_header_valid_strobe = 1'b1;
    bus.pkt_header_valid        = 1'b1;
    bus.pkt_rate                = 8'h99;
    tick();
    bus.fcs_out_strobe          = 1'b0;
    bus.pkt_header_valid_strobe = 1'b0;
    tick();
    check("t5_collide_level", 64'(bus.fifo_level), 64'd1);
    check("t5_collide_drop", 64'(bus.drop_count), 64'd1);
    fcs(1'b1);
    tick(2);
    check("t5_hdr_discarded", 64'(bus.fifo_level), 64'd1);
    pop("t5_collide_rec", rec(0, 5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -30, 50, 8'h0B));

    // Second valid header in DATA: abort A, B proceeds normally
    header(1'b1, 1'b0, 1'b0, 8'h0C, 16'd40, -11'sd44);
    send_bytes(3);
    header(1'b1, 1'b0, 1'b1, 8'h12, 16'd60, -11'sd22);
    tick();
    check("t5_abort_level", 64'(bus.fifo_level), 64'd1);
    send_bytes(7);
    fcs(1'b1);
    tick();
    check("t5_b_level", 64'(bus.fifo_level), 64'd2);
    pop("t5_abort_a", rec(1, 3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -44, 40, 8'h0C));
    pop("t5_pkt_b", rec(2, 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, -22, 60, 8'h12));

    // Invalid header in DATA: abort C, reject D one cycle later; read+write same cycle
    header(1'b1, 1'b0, 1'b0, 8'h0D, 16'd70, -11'sd50);
    send_bytes(2);
    header(1'b0, 1'b0, 1'b0, 8'h0E, 16'd80, -11'sd51);
    check("t5_cd_level0", 64'(bus.fifo_level), 64'd0);
    tick();
    check("t5_cd_level1", 64'(bus.fifo_level), 64'd1);
    pop("t5_abort_c", rec(3, 2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, -50, 70, 8'h0D));
    check("t5_rw_same_cycle", 64'(bus.fifo_level), 64'd1);
    pop("t5_reject_d", rec(4, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, -51, 80, 8'h0E));
    check("t5_empty", 64'(bus.fifo_empty), 64'd1);

    // enable=0 mid-packet drops silently
    header(1'b1, 1'b0, 1'b0, 8'h0B, 16'd10, -11'sd5);
    send_bytes(4);
    bus.enable = 1'b0;
    tick();
    bus.enable = 1'b1;
    fcs(1'b1);
    tick(2);
    check("t6_silent_level", 64'(bus.fifo_level), 64'd0);
    check("t6_silent_drop", 64'(bus.drop_count), 64'd1);
    header(1'b1, 1'b1, 1'b0, 8'h40, 16'd12, -11'sd6);
    tick();
    pop("t6_ht_reject", rec(5, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -6, 12, 8'h40));

    // RSSI ramp -60 -> -30 -> -50 during DATA
    header(1'b1, 1'b0, 1'b0, 8'h0B, 16'd30, -11'sd60);
    bus.rssi_half_db = -11'sd30;
    tick(3);
    bus.rssi_half_db = -11'sd50;
    tick(3);
    fcs(1'b1);
    tick();
`ifdef OPENOFDM_RX_RSSI_PEAK_EN
    pop("t7_rssi_peak", rec(6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -30, 30, 8'h0B));
`else
    pop("t7_rssi_hdr", rec(6, 0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, -60, 30, 8'h0B));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
